axil_bram_bridge: RTL

//  AXI4-Lite slave to single-port BRAM-style bus bridge. Drives the bram_en/bram_we/bram_addr/bram_din/bram_dout port of sys_cfg_wrap.

---
 rtl/cfg_pkg.sv | 13 +
 rtl/axil_hold_reg.sv | 41 ++++
 rtl/axil_bram_bridge.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/cfg_pkg.sv
// Shared AXI response codes and bridge FSM state encoding.
// Pure declarations: no latency and no handshakes live here.
package cfg_pkg;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WR    = 3'd1;
    localparam logic [2:0] ST_BRESP = 3'd2;
    localparam logic [2:0] ST_RD    = 3'd3;
    localparam logic [2:0] ST_RRESP = 3'd4;

endpackage

// File: rtl/axil_hold_reg.sv
// One-deep valid/ready holding register; data is visible the cycle after acceptance.
// in_rdy_o is registered and low while full or in reset; it rises the cycle after clr_i.
module axil_hold_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_dat_i,
    input  logic         in_vld_i,
    output logic         in_rdy_o,
    output logic [W-1:0] out_dat_o,
    output logic         out_vld_o,
    input  logic         clr_i
);

    logic         full_q, full_d;
    logic         rdy_q;
    logic [W-1:0] dat_q;
    logic         accept;

    assign accept = in_vld_i & rdy_q;
    // clr_i only arrives while full, so it never collides with an accept
    assign full_d = (full_q & ~clr_i) | accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= 1'b0;
            rdy_q  <= 1'b0;
            dat_q  <= '0;
        end else begin
            full_q <= full_d;
            rdy_q  <= ~full_d;
            if (accept) dat_q <= in_dat_i;
        end
    end

    assign in_rdy_o  = rdy_q;
    assign out_dat_o = dat_q;
    assign out_vld_o = full_q;

endmodule

// File: rtl/axil_bram_bridge.sv
// AXI4-Lite slave serialising reads and writes onto one single-port BRAM port, always OKAY.
// Write: bram cycle 1 after holders full, bvalid at +2; read: rvalid at +RD_LATENCY+2; B/R held until ready.
module axil_bram_bridge
    import cfg_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_NUM   = 4,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] s_awaddr,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    input  logic [DATA_WIDTH-1:0] s_wdata,
    input  logic [BYTE_NUM-1:0]   s_wstrb,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    output logic [1:0]            s_bresp,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    input  logic [ADDR_WIDTH-1:0] s_araddr,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    output logic [DATA_WIDTH-1:0] s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  s_rvalid,
    input  logic                  s_rready,
    output logic                  bram_en,
    output logic [BYTE_NUM-1:0]   bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_din,
    input  logic [DATA_WIDTH-1:0] bram_dout
);

    localparam logic [1:0] RD_LAT = 2'(RD_LATENCY);

    logic [ADDR_WIDTH-1:0] aw_addr, ar_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic [BYTE_NUM-1:0]   w_strb;
    logic                  aw_full, w_full, ar_full;
    logic                  aw_clr, w_clr, ar_clr;
    logic                  wr_rdy, rd_rdy;

    logic [2:0]            state_q, state_d;
    logic                  last_wr_q, last_wr_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  bram_en_q, bram_en_d;
    logic [BYTE_NUM-1:0]   bram_we_q, bram_we_d;
    logic [ADDR_WIDTH-1:0] bram_addr_q, bram_addr_d;
    logic [DATA_WIDTH-1:0] bram_din_q, bram_din_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  bvalid_q, bvalid_d;
    logic                  rvalid_q, rvalid_d;

    axil_hold_reg #(.W(ADDR_WIDTH)) u_aw_hold (
        .clk(clk), .rst(rst),
        .in_dat_i(s_awaddr), .in_vld_i(s_awvalid), .in_rdy_o(s_awready),
        .out_dat_o(aw_addr), .out_vld_o(aw_full), .clr_i(aw_clr)
    );

    axil_hold_reg #(.W(DATA_WIDTH + BYTE_NUM)) u_w_hold (
        .clk(clk), .rst(rst),
        .in_dat_i({s_wstrb, s_wdata}), .in_vld_i(s_wvalid), .in_rdy_o(s_wready),
        .out_dat_o({w_strb, w_data}), .out_vld_o(w_full), .clr_i(w_clr)
    );

    axil_hold_reg #(.W(ADDR_WIDTH)) u_ar_hold (
        .clk(clk), .rst(rst),
        .in_dat_i(s_araddr), .in_vld_i(s_arvalid), .in_rdy_o(s_arready),
        .out_dat_o(ar_addr), .out_vld_o(ar_full), .clr_i(ar_clr)
    );

    assign wr_rdy = aw_full & w_full;
    assign rd_rdy = ar_full;

    always_comb begin
        state_d     = state_q;
        last_wr_d   = last_wr_q;
        cnt_d       = cnt_q;
        bram_en_d   = 1'b0;
        bram_we_d   = '0;
        bram_addr_d = bram_addr_q;
        bram_din_d  = bram_din_q;
        rdata_d     = rdata_q;
        bvalid_d    = bvalid_q;
        rvalid_d    = rvalid_q;
        aw_clr      = 1'b0;
        w_clr       = 1'b0;
        ar_clr      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // on a tie, serve the direction that lost last time
                if (wr_rdy && (!rd_rdy || !last_wr_q)) begin
                    state_d     = ST_WR;
                    last_wr_d   = 1'b1;
                    bram_en_d   = 1'b1;
                    bram_we_d   = w_strb;
                    bram_addr_d = aw_addr;
                    bram_din_d  = w_data;
                end else if (rd_rdy) begin
                    state_d     = ST_RD;
                    last_wr_d   = 1'b0;
                    bram_en_d   = 1'b1;
                    bram_addr_d = ar_addr;
                    cnt_d       = 2'd0;
                end
            end
            ST_WR: begin
                aw_clr   = 1'b1;
                w_clr    = 1'b1;
                bvalid_d = 1'b1;
                state_d  = ST_BRESP;
            end
            ST_BRESP: begin
                if (s_bready) begin
                    bvalid_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            ST_RD: begin
                // cnt_q counts cycles since the enable pulse was on the bus
                if (cnt_q == RD_LAT) begin
                    rdata_d  = bram_dout;
                    rvalid_d = 1'b1;
                    ar_clr   = 1'b1;
                    state_d  = ST_RRESP;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            ST_RRESP: begin
                if (s_rready) begin
                    rvalid_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            last_wr_q   <= 1'b0;
            cnt_q       <= 2'd0;
            bram_en_q   <= 1'b0;
            bram_we_q   <= '0;
            bram_addr_q <= '0;
            bram_din_q  <= '0;
            rdata_q     <= '0;
            bvalid_q    <= 1'b0;
            rvalid_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_wr_q   <= last_wr_d;
            cnt_q       <= cnt_d;
            bram_en_q   <= bram_en_d;
            bram_we_q   <= bram_we_d;
            bram_addr_q <= bram_addr_d;
            bram_din_q  <= bram_din_d;
            rdata_q     <= rdata_d;
            bvalid_q    <= bvalid_d;
            rvalid_q    <= rvalid_d;
        end
    end

    assign bram_en   = bram_en_q;
    assign bram_we   = bram_we_q;
    assign bram_addr = bram_addr_q;
    assign bram_din  = bram_din_q;
    assign s_rdata   = rdata_q;
    assign s_bvalid  = bvalid_q;
    assign s_rvalid  = rvalid_q;
    assign s_bresp   = RESP_OKAY;
    assign s_rresp   = RESP_OKAY;

endmodule
